// File: rtl/branch_pc_sequencer_if.sv
// Branch-request handshake between decode/branch-resolve (master) and the
// fetch PC sequencer (slave).
interface branch_pc_sequencer_if;
    logic        br_valid;
    logic        br_taken;
    logic [15:0] br_imm16;
    logic [31:0] br_pc4;
    logic        br_ack;

    modport master (
        output br_valid,
        output br_taken,
        output br_imm16,
        output br_pc4,
        input  br_ack
    );

    modport slave (
        input  br_valid,
        input  br_taken,
        input  br_imm16,
        input  br_pc4,
        output br_ack
    );
endinterface

// File: rtl/branch_pc_sequencer.sv
// Fetch PC owner: sequential +PC_STEP advance, and a two-cycle redirect
// (ack, then flush) to br_pc4 + sign_extend(imm16)<<2 on a taken branch.
module branch_pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0040_0020,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic                        stall,
    input  logic                        fetch_ready,
    branch_pc_sequencer_if.slave        br,
    output logic [31:0]                 pc,
    output logic                        pc_valid,
    output logic                        flush,
    output logic                        align_err
);

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] REDIR = 2'd2;

    logic [1:0]  state_q;
    logic [31:0] pc_q;
    logic [31:0] tgt_q;
    logic        flush_q;
    logic        align_q;

    logic        accept;
    logic        take;
    logic [31:0] br_sum;

    assign accept = (state_q == RUN) && br.br_valid && !stall;
    assign take   = accept && br.br_taken;
    assign br_sum = br.br_pc4 + {{14{br.br_imm16[15]}}, br.br_imm16, 2'b00};

    assign br.br_ack = accept;
    assign pc        = pc_q;
    assign pc_valid  = (state_q == RUN);
    assign flush     = flush_q;
    assign align_err = align_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
            flush_q <= 1'b0;
            align_q <= 1'b0;
        end else begin
            flush_q <= take;
            case (state_q)
                BOOT: begin
                    state_q <= RUN;
                end
                RUN: begin
                    if (take) begin
                        // Branch beats a concurrent fetch: pc holds until REDIR loads the target.
                        state_q <= REDIR;
                        tgt_q   <= {br_sum[31:2], 2'b00};
                        if (br.br_pc4[1:0] != 2'b00) begin
                            align_q <= 1'b1;
                        end
                    end else if (fetch_ready && !stall) begin
                        pc_q <= pc_q + PC_STEP;
                    end
                end
                REDIR: begin
                    state_q <= RUN;
                    pc_q    <= tgt_q;
                end
                default: begin
                    state_q <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Directed self-checking bench for branch_pc_sequencer: boot, sequential fetch,
// taken/not-taken redirects, stall priority, wrap, alignment error, reset in REDIR.
module tb_branch_pc_sequencer;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        stall;
    logic        fetch_ready;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        align_err;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    branch_pc_sequencer_if br_if ();

    branch_pc_sequencer #(
        .RESET_PC (32'h0040_0020),
        .PC_STEP  (32'd4)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .stall       (stall),
        .fetch_ready (fetch_ready),
        .br          (br_if.slave),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .flush       (flush),
        .align_err   (align_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic branch(input logic taken, input logic [31:0] pc4, input logic [15:0] imm);
        br_if.br_valid = 1'b1;
        br_if.br_taken = taken;
        br_if.br_pc4   = pc4;
        br_if.br_imm16 = imm;
    endtask

    initial begin
        arst_n         = 1'b0;
        stall          = 1'b0;
        fetch_ready    = 1'b0;
        br_if.br_valid = 1'b0;
        br_if.br_taken = 1'b0;
        br_if.br_pc4   = '0;
        br_if.br_imm16 = '0;

        #12;
        check("rst_pc",        pc,                32'h0040_0020);
        check("rst_pc_valid",  {31'd0, pc_valid}, 32'd0);
        check("rst_flush",     {31'd0, flush},    32'd0);
        check("rst_ack",       {31'd0, br_if.br_ack}, 32'd0);
        check("rst_align",     {31'd0, align_err},    32'd0);

        // Boot cycle ignores fetch_ready
        arst_n      = 1'b1;
        fetch_ready = 1'b1;
        #1;
        check("boot_pc_valid", {31'd0, pc_valid}, 32'd0);
        tick();
        check("run_pc0",       pc,                32'h0040_0020);
        check("run_pc_valid",  {31'd0, pc_valid}, 32'd1);
        tick();
        check("run_pc1",       pc,                32'h0040_0024);
        tick();
        check("run_pc2",       pc,                32'h0040_0028);
        fetch_ready = 1'b0;

        // Forward taken branch: +4 words
        branch(1'b1, 32'h0040_0030, 16'h0004);
        #1;
        check("fwd_ack",       {31'd0, br_if.br_ack}, 32'd1);
        tick();
        check("fwd_flush",     {31'd0, flush},        32'd1);
        check("fwd_redir_pcv", {31'd0, pc_valid},     32'd0);
        check("fwd_redir_ack", {31'd0, br_if.br_ack}, 32'd0);
        check("fwd_redir_pc",  pc,                    32'h0040_0028);
        br_if.br_valid = 1'b0;
        tick();
        check("fwd_pc",        pc,                    32'h0040_0040);
        check("fwd_pcv",       {31'd0, pc_valid},     32'd1);
        check("fwd_flush_off", {31'd0, flush},        32'd0);

        // Backward taken branch: -2 words
        branch(1'b1, 32'h0040_0030, 16'hFFFE);
        tick();
        br_if.br_valid = 1'b0;
        tick();
        check("neg_pc",        pc,                    32'h0040_0028);

        // Redirect to top of address space, then wrap on fetch
        branch(1'b1, 32'hFFFF_FFF8, 16'h0001);
        tick();
        br_if.br_valid = 1'b0;
        tick();
        check("top_pc",        pc,                    32'hFFFF_FFFC);
        fetch_ready = 1'b1;
        tick();
        check("wrap_pc",       pc,                    32'h0000_0000);
        fetch_ready = 1'b0;

        // Stall blocks acceptance and freezes pc
        stall       = 1'b1;
        fetch_ready = 1'b1;
        branch(1'b1, 32'h0040_0100, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_ack",  {31'd0, br_if.br_ack}, 32'd0);
            tick();
            check("stall_pc",   pc,                    32'h0000_0000);
            check("stall_flush", {31'd0, flush},       32'd0);
        end
        stall = 1'b0;
        #1;
        check("unstall_ack",   {31'd0, br_if.br_ack}, 32'd1);
        tick();
        check("br_wins_pc",    pc,                    32'h0000_0000);
        check("br_wins_flush", {31'd0, flush},        32'd1);
        br_if.br_valid = 1'b0;
        fetch_ready    = 1'b0;
        tick();
        check("unstall_tgt",   pc,                    32'h0040_0100);

        // Misaligned branch base: sticky error, target forced word-aligned
        branch(1'b1, 32'h0040_0031, 16'h0001);
        tick();
        check("align_set",     {31'd0, align_err},    32'd1);
        br_if.br_valid = 1'b0;
        tick();
        check("align_tgt",     pc,                    32'h0040_0034);

        // Not-taken: ack, no flush, sequential advance
        branch(1'b0, 32'h0040_0500, 16'h0010);
        fetch_ready = 1'b1;
        #1;
        check("nt_ack",        {31'd0, br_if.br_ack}, 32'd1);
        tick();
        br_if.br_valid = 1'b0;
        fetch_ready    = 1'b0;
        check("nt_flush",      {31'd0, flush},        32'd0);
        check("nt_pc",         pc,                    32'h0040_0038);
        check("nt_pcv",        {31'd0, pc_valid},     32'd1);
        check("align_sticky",  {31'd0, align_err},    32'd1);

        // Reset during REDIR discards the pending redirect
        branch(1'b1, 32'h0040_0200, 16'h0000);
        tick();
        check("pre_rst_flush", {31'd0, flush},        32'd1);
        br_if.br_valid = 1'b0;
        #1;
        arst_n = 1'b0;
        #1;
        check("ar_pc",         pc,                    32'h0040_0020);
        check("ar_flush",      {31'd0, flush},        32'd0);
        check("ar_pcv",        {31'd0, pc_valid},     32'd0);
        check("ar_align",      {31'd0, align_err},    32'd0);
        #1;
        arst_n = 1'b1;
        tick();
        check("ar_boot_pc",    pc,                    32'h0040_0020);
        check("ar_run_pcv",    {31'd0, pc_valid},     32'd1);
        tick();
        check("ar_no_redir",   pc,                    32'h0040_0020);
        check("ar_no_flush",   {31'd0, flush},        32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
